biss_sniffer: RTL and testbench
===============================

BISS_SNIFFER -- requirements
Module: biss_sniffer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, sets the synchroniser depth on ssi_sck_i/ssi_dat_i.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1250, sets the clk_i cycles of SCK-high that abort a frame in progress (10 us at 125 MHz).
REQ-003 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-004 SHALL have port reset_i, input, 1, synchronous active-low reset.
REQ-005 SHALL have port BITS, input, 8, position field width in bits.
REQ-006 SHALL have port BITS_CRC, input, 8, bits after the position field: nE, nW, then CRC; 8 gives 2 status bits plus CRC6.
REQ-007 SHALL have port ssi_sck_i, input, 1, BiSS-C MA line driven by the master, asynchronous, idle high.
REQ-008 SHALL have port ssi_dat_i, input, 1, BiSS-C SLO line driven by the slave, asynchronous, idle high.
REQ-009 SHALL have port posn_o, output, 32, last accepted position, sign-extended.

Function
REQ-010 SHALL be passive: it only observes the lines and never drives them.
REQ-011 SHALL pass both lines through SYNC_STAGES flops, then detect SCK rising edges with a one-cycle strobe.
REQ-012 SHALL sample data only on synchronised SCK rising edges.
REQ-013 SHALL run these states: IDLE -> ACK -> START -> CDS -> POSN -> STAT -> CRC -> CHECK -> TIMEOUT -> IDLE.
REQ-014 IDLE: leave on the first SCK falling edge.
REQ-015 ACK: wait for a sampled 0.
REQ-016 START: wait for a sampled 1.
REQ-017 CDS: skip one bit.
REQ-018 POSN: shift in BITS bits, MSB first.
REQ-019 STAT: capture nE, then nW.
REQ-020 CRC: shift in BITS_CRC-2 bits, MSB first.
REQ-021 CHECK: lasts one cycle; when the frame is accepted, load posn_o with the shifted position, sign-extended from bit BITS-1.
REQ-022 TIMEOUT: wait until the synchronised data line is high, then go to IDLE.
REQ-023 Bit counters SHALL be 8 bits wide.
REQ-024 BITS of 0 or >32 SHALL be treated as 32.
REQ-025 BITS_CRC <2 SHALL be treated as 2, meaning no CRC bits.
REQ-026 In any state other than IDLE/TIMEOUT, SCK held high for TIMEOUT_CYCLES consecutive cycles SHALL abort the frame to IDLE with posn_o unchanged.
REQ-027 posn_o SHALL change only in CHECK; a partial or aborted frame never alters it.
REQ-028 A frame ending and an SCK edge arriving in the same cycle: the edge is ignored; the next frame starts from IDLE.
REQ-029 The error and warning bits SHALL NOT gate acceptance.

Reset
REQ-030 With reset_i low at a clk_i edge: state=IDLE, counters=0, shift registers=0, posn_o=0, synchronisers=1 (idle level).
REQ-031 Reset asserted mid-frame SHALL discard the frame; posn_o returns to 0.

Configuration
REQ-032 With BISS_SNIFFER_CRC_CHECK_EN defined: compute BiSS CRC6 (poly x^6+x+1, seed 0) over position, nE and nW; invert the result; accept only if it equals the received CRC; apply the check only when BITS_CRC==8, otherwise accept.
REQ-033 Without BISS_SNIFFER_CRC_CHECK_EN: CRC bits are clocked through and ignored; every complete frame is accepted.

Structure
REQ-034 SHALL provide package biss_sniffer_pkg holding the state enum, CRC6 polynomial constant 6'h03, CRC width 6 and max position width 32.
REQ-035 SHALL instantiate one sub-module, biss_crc6, a serial CRC6 with enable, clear and data-bit input, cleared in START.

Verification
REQ-036 Idle lines, reset released -> posn_o=0; no state change over 10000 cycles.
REQ-037 BITS=32, BITS_CRC=8, frame with position 0x12345678, nE=nW=1, correct CRC, SCK period 200 ns -> posn_o=0x12345678 within 5 cycles after the last CRC bit.
REQ-038 BITS=16, position 0x8001 -> posn_o=0xFFFF8001.
REQ-039 BISS_SNIFFER_CRC_CHECK_EN defined, CRC bit flipped -> posn_o keeps its previous value; the next good frame with 0x00000055 -> 0x00000055.
REQ-040 SCK stops high after 10 position bits for 1300 cycles, then a full frame with 0x0000ABCD -> abort, then posn_o=0x0000ABCD.
REQ-041 reset_i low during POSN -> posn_o=0; the next complete frame is decoded correctly.

Source files
------------

// File: rtl/biss_sniffer_pkg.sv
// biss_sniffer_pkg: shared types, CRC6 constants and position helpers for the BiSS-C sniffer.
package biss_sniffer_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ACK, S_START, S_CDS, S_POSN, S_STAT, S_CRC, S_CHECK, S_TIMEOUT
  } state_t;
  localparam int CRC_W = 6;
  localparam logic [CRC_W-1:0] CRC_POLY = 6'h03;
  localparam int MAX_POSN = 32;
  function automatic logic [MAX_POSN-1:0] sext(input logic [MAX_POSN-1:0] v, input logic [7:0] n);
    logic [MAX_POSN-1:0] m;
    m = {MAX_POSN{1'b1}} << n;
    return v[5'(n - 8'd1)] ? (v | m) : (v & ~m);
  endfunction
endpackage

// File: rtl/biss_crc6.sv
// biss_crc6: serial CRC6 (x^6+x+1, zero seed), MSB-first data bit per enable.
module biss_crc6
  import biss_sniffer_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en,
  input  logic             clr,
  input  logic             d,
  output logic [CRC_W-1:0] crc
);
  logic fb;
  assign fb = crc[CRC_W-1] ^ d;
  always_ff @(posedge clk_i) begin
    if (!reset_i || clr) crc <= '0;
    else if (en) crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  end
endmodule

// File: rtl/biss_sniffer.sv
// biss_sniffer: passive BiSS-C frame sniffer recovering the sign-extended position word.
// Define BISS_SNIFFER_CRC_CHECK_EN to drop frames whose inverted CRC6 does not match.
module biss_sniffer
  import biss_sniffer_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1250
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  BITS,
  input  logic [7:0]  BITS_CRC,
  input  logic        ssi_sck_i,
  input  logic        ssi_dat_i,
  output logic [31:0] posn_o
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic [SYNC_STAGES-1:0] sck_sync, dat_sync;
  logic sck, dat, sck_q, rise, fall;
  logic [7:0] bits_eff, crc_eff, cnt;
  logic [MAX_POSN-1:0] pos_sr;
  logic [1:0] stat;
  logic [CRC_W-1:0] crc_sr, crc_calc;
  logic [TO_W-1:0] to_cnt;
  logic timing, to_hit, crc_ok, unused_obs;
  assign sck = sck_sync[SYNC_STAGES-1];
  assign dat = dat_sync[SYNC_STAGES-1];
  assign rise = sck & ~sck_q;
  assign fall = ~sck & sck_q;
  assign bits_eff = (BITS == 8'd0 || BITS > 8'(MAX_POSN)) ? 8'(MAX_POSN) : BITS;
  assign crc_eff = (BITS_CRC < 8'd2) ? 8'd2 : BITS_CRC;
  assign timing = sck && state != S_IDLE && state != S_TIMEOUT;
  assign to_hit = timing && to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
`ifdef BISS_SNIFFER_CRC_CHECK_EN
  assign crc_ok = (BITS_CRC != 8'd8) || (~crc_calc == crc_sr);
  assign unused_obs = ^stat;
`else
  assign crc_ok = 1'b1;
  assign unused_obs = ^{stat, crc_calc, crc_sr};
`endif
  biss_crc6 u_crc (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en     (rise && (state == S_POSN || state == S_STAT)),
    .clr    (state == S_START),
    .d      (dat),
    .crc    (crc_calc)
  );
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sck_sync <= '1;
      dat_sync <= '1;
      sck_q <= 1'b1;
    end else begin
      sck_sync <= SYNC_STAGES'({sck_sync, ssi_sck_i});
      dat_sync <= SYNC_STAGES'({dat_sync, ssi_dat_i});
      sck_q <= sck;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state <= S_IDLE;
      cnt <= '0;
      pos_sr <= '0;
      stat <= '0;
      crc_sr <= '0;
      to_cnt <= '0;
      posn_o <= '0;
    end else begin
      to_cnt <= timing ? to_cnt + 1'b1 : '0;
      if (to_hit) state <= S_IDLE;
      else begin
        case (state)
          S_IDLE: if (fall) state <= S_ACK;
          S_ACK: if (rise && !dat) state <= S_START;
          S_START: begin
            cnt <= '0;
            pos_sr <= '0;
            crc_sr <= '0;
            if (rise && dat) state <= S_CDS;
          end
          S_CDS: if (rise) state <= S_POSN;
          S_POSN: if (rise) begin
            pos_sr <= {pos_sr[MAX_POSN-2:0], dat};
            cnt <= (cnt == bits_eff - 8'd1) ? 8'd0 : cnt + 8'd1;
            if (cnt == bits_eff - 8'd1) state <= S_STAT;
          end
          S_STAT: if (rise) begin
            stat <= {stat[0], dat};
            cnt <= (cnt == 8'd1) ? 8'd0 : cnt + 8'd1;
            if (cnt == 8'd1) state <= (crc_eff == 8'd2) ? S_CHECK : S_CRC;
          end
          S_CRC: if (rise) begin
            crc_sr <= {crc_sr[CRC_W-2:0], dat};
            cnt <= (cnt == crc_eff - 8'd3) ? 8'd0 : cnt + 8'd1;
            if (cnt == crc_eff - 8'd3) state <= S_CHECK;
          end
          S_CHECK: begin
            if (crc_ok) posn_o <= sext(pos_sr, bits_eff);
            state <= S_TIMEOUT;
          end
          S_TIMEOUT: if (dat) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_biss_sniffer.sv
// tb_biss_sniffer: directed BiSS-C frames with a scoreboard watching posn_o updates.
module tb_biss_sniffer;
  import biss_sniffer_pkg::*;
  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  logic [7:0] BITS = 8'd32;
  logic [7:0] BITS_CRC = 8'd8;
  logic ssi_sck_i = 1'b1;
  logic ssi_dat_i = 1'b1;
  logic [31:0] posn_o;
  logic [31:0] exp_q[$];
  logic [31:0] last_posn = '0;
  bit mon_en = 1'b0;
  int total = 0;
  int bad = 0;

  biss_sniffer dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .BITS     (BITS),
    .BITS_CRC (BITS_CRC),
    .ssi_sck_i(ssi_sck_i),
    .ssi_dat_i(ssi_dat_i),
    .posn_o   (posn_o)
  );

  always #4 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Remainder of message*x^6 divided by x^6+x+1; message = position, nE=1, nW=1
  function automatic logic [5:0] crc6_model(input logic [31:0] pos, input int nb);
    logic [6:0] r;
    logic b;
    r = '0;
    for (int i = 0; i < nb + 8; i++) begin
      b = (i < nb) ? pos[nb-1-i] : (i < nb + 2);
      r = {r[5:0], b};
      if (r[6]) r = r ^ 7'h43;
    end
    return r[5:0];
  endfunction

  task automatic frame(input logic [7:0] b, input logic [7:0] bc, input logic [31:0] pos,
                       input int stop, input bit flip, input logic [31:0] exp, input string nm);
    int nb, nc, n;
    logic [5:0] c;
    bit q[$];
    nb = (b == 0 || b > 32) ? 32 : int'(b);
    nc = (bc < 2) ? 2 : int'(bc);
    BITS = b;
    BITS_CRC = bc;
    q.push_back(1'b1);
    q.push_back(1'b0);
    q.push_back(1'b1);
    q.push_back(1'b0);
    for (int i = nb - 1; i >= 0; i--) q.push_back(pos[i]);
    q.push_back(1'b1);
    q.push_back(1'b1);
    if (nc == 8) begin
      c = ~crc6_model(pos, nb);
      c[0] = c[0] ^ flip;
      for (int i = 5; i >= 0; i--) q.push_back(c[i]);
    end else begin
      for (int i = 0; i < nc - 2; i++) q.push_back(1'b0);
    end
    n = (stop < 0) ? q.size() : 4 + stop;
    @(negedge clk_i);
    #2;
    for (int i = 0; i < n; i++) begin
      ssi_sck_i = 1'b0;
      ssi_dat_i = q[i];
      #100;
      ssi_sck_i = 1'b1;
      if (i < n - 1) #100;
    end
    if (stop < 0) begin
      repeat (5) @(posedge clk_i);
      #1;
      check(nm, posn_o, exp);
      #100 ssi_dat_i = 1'b0;
      #400 ssi_dat_i = 1'b1;
      #400;
    end
  endtask

  always @(negedge clk_i) begin
    if (mon_en && posn_o !== last_posn) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %h expected no update", posn_o);
      end else check("sb_posn", posn_o, exp_q.pop_front());
    end
    last_posn = posn_o;
  end

  initial begin
    int chg;
    logic [31:0] bad_exp;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    mon_en = 1'b1;
    check("reset_posn", posn_o, 32'h0);
    chg = 0;
    repeat (10000) begin
      @(negedge clk_i);
      if (dut.state != S_IDLE) chg++;
    end
    check("idle_state_changes", 32'(chg), 32'd0);
    check("idle_posn", posn_o, 32'h0);

    exp_q.push_back(32'h12345678);
    frame(8'd32, 8'd8, 32'h12345678, -1, 1'b0, 32'h12345678, "posn32");
    exp_q.push_back(32'hFFFF8001);
    frame(8'd16, 8'd8, 32'h00008001, -1, 1'b0, 32'hFFFF8001, "posn16_sext");
`ifdef BISS_SNIFFER_CRC_CHECK_EN
    bad_exp = 32'hFFFF8001;
`else
    bad_exp = 32'h00000033;
    exp_q.push_back(bad_exp);
`endif
    frame(8'd32, 8'd8, 32'h00000033, -1, 1'b1, bad_exp, "bad_crc");
    exp_q.push_back(32'h00000055);
    frame(8'd32, 8'd8, 32'h00000055, -1, 1'b0, 32'h00000055, "after_bad_crc");

    frame(8'd32, 8'd8, 32'h0000ABCD, 10, 1'b0, 32'h0, "partial");
    repeat (1300) @(posedge clk_i);
    #1;
    check("abort_state", 32'(dut.state), 32'(S_IDLE));
    check("abort_posn", posn_o, 32'h00000055);
    exp_q.push_back(32'h0000ABCD);
    frame(8'd32, 8'd8, 32'h0000ABCD, -1, 1'b0, 32'h0000ABCD, "after_abort");

    exp_q.push_back(32'h80000001);
    frame(8'd0, 8'd8, 32'h80000001, -1, 1'b0, 32'h80000001, "bits0_as_32");
    exp_q.push_back(32'h0F0F0F0F);
    frame(8'd40, 8'd8, 32'h0F0F0F0F, -1, 1'b0, 32'h0F0F0F0F, "bits40_as_32");
    exp_q.push_back(32'hFFFFFFA5);
    frame(8'd8, 8'd0, 32'h000000A5, -1, 1'b0, 32'hFFFFFFA5, "no_crc_bits");

    frame(8'd16, 8'd8, 32'h00001234, 5, 1'b0, 32'h0, "partial_rst");
    exp_q.push_back(32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    check("reset_mid_posn", posn_o, 32'h0);
    exp_q.push_back(32'h00001234);
    frame(8'd16, 8'd8, 32'h00001234, -1, 1'b0, 32'h00001234, "after_reset");

    repeat (20) @(posedge clk_i);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
